// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin sequencer that shares one registered 8-bit adder among
//   NUM_REQ requesters. It accepts one request at a time and drives the
//   adder operands. It waits out the adder latency, then returns sum/cout
//   tagged with the id of the requester that was served.
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_cin       packed operands, requester i at [8*i+7:8*i] / bit i
//   adder_a/adder_b/adder_cin operands to the shared adder
//   adder_sum/adder_cout      result from the shared adder
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_sum/rsp_cout   response payload
//   busy                      high whenever the sequencer is not idle
module adder_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ADDER_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  output logic [7:0]           adder_a,
  output logic [7:0]           adder_b,
  output logic                 adder_cin,
  input  logic [7:0]           adder_sum,
  input  logic                 adder_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        op_a_q, op_a_d;
  logic [7:0]        op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [7:0]        rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;

  logic              win_found;
  int                win_i;
  int                cand;

  // Round-robin search: first valid requester strictly after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_i     = 0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_i     = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        // Grant is withheld while reset is asserted so no requester sees a
        // handshake that the reset edge would discard.
        if (win_found && !rst) begin
          req_ready[win_i] = 1'b1;
          op_a_d           = req_a[8*win_i +: 8];
          op_b_d           = req_b[8*win_i +: 8];
          op_cin_d         = req_cin[win_i];
          id_d             = ID_W'(win_i);
          rr_ptr_d         = ID_W'(win_i);
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        // The adder samples the operand registers at the end of this cycle.
        cnt_d   = CNT_W'(ADDER_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_sum_d   = adder_sum;
          rsp_cout_d  = adder_cout;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign adder_a   = op_a_q;
  assign adder_b   = op_b_q;
  assign adder_cin = op_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != IDLE);

endmodule
